// File: rtl/sqrt_q4_4_pkg.sv
// Shared widths and state encoding for the Q4.4 square-root unit.
// The radicand is the Q4.4 operand with four extra fraction bits; its 6-bit root is the Q4.4 result.
package sqrt_pkg;

  localparam int IN_W   = 8;
  localparam int FRAC_W = 4;
  localparam int RAD_W  = 12;
  localparam int ROOT_W = 6;
  localparam int REM_W  = 8;
  localparam int ITER   = 6;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sqrt_q4_4_if.sv
// Operand/result bundle for the square-root unit.
// The requester drives the operand and load strobe; the unit returns the root and its done flag.
interface sqrt_q4_4_if;
  import sqrt_pkg::*;

  logic [IN_W-1:0] N;
  logic            ld;
  logic [IN_W-1:0] result;
  logic            flag;

  modport master (output N, output ld, input result, input flag);
  modport slave  (input N, input ld, output result, output flag);

endinterface

// File: rtl/sqrt_q4_4_step.sv
// One restoring square-root iteration: bring down two radicand bits and conditionally subtract the trial value.
module sqrt_step
  import sqrt_pkg::*;
(
  input  logic [REM_W-1:0]  rem_in,
  input  logic [ROOT_W-1:0] root_in,
  input  logic [1:0]        pair,
  output logic [REM_W-1:0]  rem_out,
  output logic              bit_out
);

  logic [REM_W+1:0] shifted;
  logic [REM_W+1:0] trial;

  // The compare runs two bits wider than the stored remainder so no borrow or overflow is lost;
  // the kept remainder always fits back into REM_W bits because it never exceeds twice the root.
  always_comb begin
    shifted = {rem_in, pair};
    trial   = {2'b00, root_in, 2'b01};
    bit_out = (shifted >= trial);
    rem_out = bit_out ? REM_W'(shifted - trial) : REM_W'(shifted);
  end

endmodule

// File: rtl/sqrt_q4_4.sv
// Sequential Q4.4 square root: loads an operand, resolves one root bit per clock over six clocks,
// then holds the result with the done flag until the next load.
module sqrt_q4_4
  import sqrt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  sqrt_q4_4_if.slave  bus
);

  state_t            state;
  logic [RAD_W-1:0]  rad;
  logic [REM_W-1:0]  rem;
  logic [ROOT_W-1:0] root;
  logic [CNT_W-1:0]  cnt;
  logic [IN_W-1:0]   result_q;
  logic              flag_q;

  logic [REM_W-1:0]  rem_nxt;
  logic              bit_nxt;

  sqrt_step u_step (
    .rem_in  (rem),
    .root_in (root),
    .pair    (rad[RAD_W-1 -: 2]),
    .rem_out (rem_nxt),
    .bit_out (bit_nxt)
  );

  // Load takes priority in every state; the radicand shifts left so the next pair is always on top.
  // The result register only changes on the completing iteration, so it keeps the old root while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      cnt      <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else if (bus.ld) begin
      state  <= BUSY;
      rad    <= {bus.N, {FRAC_W{1'b0}}};
      rem    <= '0;
      root   <= '0;
      cnt    <= '0;
      flag_q <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          rad  <= {rad[RAD_W-3:0], 2'b00};
          rem  <= rem_nxt;
          root <= {root[ROOT_W-2:0], bit_nxt};
          cnt  <= cnt + 3'd1;
          if (cnt == CNT_W'(ITER - 1)) begin
            result_q <= {{(IN_W-ROOT_W){1'b0}}, root[ROOT_W-2:0], bit_nxt};
            flag_q   <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.flag   = flag_q;

endmodule

// File: tb/tb_sqrt_q4_4.sv
// Self-checking bench for sqrt_q4_4: directed table, full sweep, random operands and control corners,
// all judged against an arithmetic floor(sqrt(16*N)) model.
module tb_sqrt_q4_4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] modelResult = 8'h00;

  sqrt_q4_4_if bus ();

  sqrt_q4_4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] n;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[7];

  // Largest r with r*r <= 16*n, found by plain counting.
  function automatic logic [7:0] refSqrt(input logic [7:0] n);
    int r = 0;
    while ((r + 1) * (r + 1) <= 16 * int'(n)) r++;
    return 8'(r);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds ld high for 'hold' edges with operand n, then drops it and scrambles N.
  task automatic applyStimulus(input logic [7:0] n, input int hold);
    for (int i = 0; i < hold; i++) begin
      bus.N  = (i == hold - 1) ? n : 8'($urandom);
      bus.ld = 1'b1;
      tick();
    end
    bus.ld = 1'b0;
    bus.N  = 8'($urandom);
  endtask

  task automatic runAndCheck(input string name, input logic [7:0] n, input logic [7:0] exp, input int hold);
    int busyBad = 0;
    applyStimulus(n, hold);
    for (int i = 1; i <= 5; i++) begin
      bus.N = 8'($urandom);
      tick();
      if (bus.flag !== 1'b0 || bus.result !== modelResult) busyBad++;
    end
    checkOutput({name, " busy"}, busyBad, 0);
    tick();
    checkOutput({name, " result"}, bus.result, exp);
    checkOutput({name, " flag"}, bus.flag, 1'b1);
    modelResult = exp;
  endtask

  initial begin
    int bad;
    vecs[0] = '{8'h90, 8'h30, "n90"};
    vecs[1] = '{8'h58, 8'h25, "n58"};
    vecs[2] = '{8'h62, 8'h27, "n62"};
    vecs[3] = '{8'h00, 8'h00, "n00"};
    vecs[4] = '{8'h01, 8'h04, "n01"};
    vecs[5] = '{8'h40, 8'h20, "n40"};
    vecs[6] = '{8'hFF, 8'h3F, "nFF"};

    rst = 1'b1; bus.ld = 1'b0; bus.N = 8'h00;
    tick(); tick();
    checkOutput("reset result", bus.result, 8'h00);
    checkOutput("reset flag", bus.flag, 1'b0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      bus.N = 8'($urandom);
      tick();
      if (bus.result !== 8'h00 || bus.flag !== 1'b0) bad++;
    end
    checkOutput("idle hold", bad, 0);

    for (int i = 0; i < 7; i++) runAndCheck(vecs[i].name, vecs[i].n, vecs[i].exp, 1);

    // Result and flag stay put in DONE while N wanders.
    runAndCheck("hold90", 8'h90, 8'h30, 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      bus.N = 8'($urandom);
      tick();
      if (bus.result !== 8'h30 || bus.flag !== 1'b1) bad++;
    end
    checkOutput("done stable", bad, 0);

    for (int n = 0; n < 256; n++) runAndCheck("sweep", 8'(n), refSqrt(8'(n)), 1);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] rn;
      rn = 8'($urandom);
      runAndCheck("random", rn, refSqrt(rn), 1);
    end

    // Reload at iteration 3 restarts the whole computation.
    applyStimulus(8'hFF, 1);
    tick(); tick(); tick();
    runAndCheck("restart", 8'h58, 8'h25, 1);

    // Reset in the middle of a computation clears outputs immediately.
    applyStimulus(8'h62, 1);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst result", bus.result, 8'h00);
    checkOutput("midrst flag", bus.flag, 1'b0);
    tick();
    rst = 1'b0;
    modelResult = 8'h00;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.result !== 8'h00 || bus.flag !== 1'b0) bad++;
    end
    checkOutput("post rst idle", bad, 0);

    runAndCheck("hold4", 8'h62, 8'h27, 4);

    // A load on the completing edge wins: no flag, no result update.
    applyStimulus(8'h90, 1);
    for (int i = 0; i < 5; i++) tick();
    bus.N  = 8'h40;
    bus.ld = 1'b1;
    tick();
    bus.ld = 1'b0;
    checkOutput("ldwin flag", bus.flag, 1'b0);
    checkOutput("ldwin result", bus.result, modelResult);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("ldwin early flag", bus.flag, 1'b0);
    tick();
    checkOutput("ldwin final", bus.result, 8'h20);
    checkOutput("ldwin final flag", bus.flag, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sqrt_q4_4.md
# sqrt_q4_4

Sequential unsigned fixed-point square-root unit. It takes an 8-bit Q4.4 operand, computes its square root with a restoring digit-by-digit algorithm that resolves one result bit per clock, and returns an 8-bit Q4.4 result with a completion flag. It serves as a small arithmetic coprocessor for datapaths that hold Q4.4 values.

## Interface
Parameters: none. Widths are fixed by the shared package.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous and active-high
- `N`  in  8  radicand, unsigned Q4.4 (value = N/16)
- `ld`  in  1  load/start; sampled on rising `clk`
- `result`  out  8  square root, unsigned Q4.4, truncated (floor)
- `flag`  out  1  done; high while `result` holds the root of the last loaded `N`

Reset: one clock; reset is asynchronous and active-high.

## Operation
- Arithmetic:
  - `result = floor(sqrt(N << 4))`, because sqrt(N/16)·16 = sqrt(16·N).
  - The 12-bit internal radicand R = {N, 4'b0000} yields a 6-bit root; `result[7:6]` is always 0.
  - Maximum input 0xFF gives 0x3F.
- Algorithm: restoring (conditional-subtract) square root, six iterations.
  - Per iteration: bring down the next 2 radicand bits into the remainder (8 bits, allow a 9-bit borrow).
  - Trial value = {root, 2'b01}.
  - If remainder ≥ trial: remainder −= trial, shift 1 into root. Otherwise shift 0.
- FSM states: IDLE, BUSY, DONE.
  - Any state, `ld`=1 at an edge: capture `N`, clear root/remainder/counter, clear `flag`, go to BUSY. `ld` has priority over everything except `rst`.
  - BUSY, `ld`=0: perform one iteration per edge. After the 6th iteration, register the root into `result`, set `flag`, go to DONE.
  - DONE: hold `result` and `flag`=1 until the next `ld` or `rst`.
  - IDLE: outputs hold their reset values.
- `ld` held high for several cycles: reload every edge; computation starts on the first edge with `ld`=0.
- `N` is only sampled on `ld` edges. Changes to `N` during BUSY or DONE are ignored.
- `result` keeps its previous value during BUSY and updates only at completion. Consumers qualify it with `flag`.

## Timing
- Reset values: `result`=0x00, `flag`=0, state IDLE, internal registers 0.
- Latency: if edge k is the last edge with `ld`=1, then `result` and `flag` update at edge k+6. `flag` rises in that same cycle.
- Throughput: one operation per 7 edges minimum (1 load + 6 iterate).
- `rst` asserted mid-BUSY: immediate return to IDLE with reset values. There is no partial result.
- `ld` asserted on the completing edge: load wins, `flag` stays 0, `result` is not updated.

## Structure
- Package `sqrt_pkg`:
  - `IN_W`=8, `FRAC_W`=4, `RAD_W`=12, `ROOT_W`=6, `ITER`=6
  - state enum {IDLE, BUSY, DONE}
- One combinational sub-module, `sqrt_step`:
  - Inputs: remainder, root, next 2 radicand bits.
  - Outputs: new remainder, new root bit.
  - Implements the conditional subtract.
- Top: holds registers, the 3-bit iteration counter and the FSM.

## Test plan
- Reset asserted, then released → `result`=0x00 and `flag`=0. Stays so with `ld`=0.
- Pulse `ld` with N=0x90 (9.0) → at 6 edges after load, `result`=0x30 (3.0) and `flag`=1, held stable.
- N=0x58 (5.5) → `result`=0x25 (2.3125). N=0x62 → `result`=0x27 (2.4375). `flag` is low during the 6 compute cycles.
- Boundaries:
  - N=0x00 → 0x00
  - N=0x01 → 0x04
  - N=0x40 → 0x20
  - N=0xFF → 0x3F
- Sweep: all 256 N values compared against floor(sqrt(16·N)).
- Timing and control corners:
  - Re-assert `ld` at iteration 3 → restart; completion occurs 6 edges after the new load.
  - Assert `rst` mid-BUSY → immediate 0x00/0 outputs.
  - Hold `ld` high 4 cycles → completion occurs 6 edges after the last high edge.
